// File: rtl/alu_cmd_seq.sv
// Command sequencer for the 4-bit ALU: buffers opcode/operand commands in a FIFO,
// issues one strobe per command, waits the ALU latency and returns captured results in order.
`timescale 1ns/1ps
module alu_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [3:0] AH_in,
  output logic [3:0] BREG_in,
  output logic       alu_add,
  output logic       alu_sub,
  output logic       alu_and,
  output logic       alu_mul,
  output logic       alu_div,
  output logic       al_lsb,
  input  logic [3:0] ALU_out,
  input  logic       sign_flag,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [2:0] res_flags,
  output logic       res_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LAT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t           state;
  logic [2:0]       fifo_op [DEPTH];
  logic [3:0]       fifo_a  [DEPTH];
  logic [3:0]       fifo_b  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;
  logic [5:0]       stb;
  logic [5:0]       head_stb;
  logic [LAT_W-1:0] wait_cnt;

  // Opcodes 6 and 7 map to no strobe, which marks them illegal.
  function automatic logic [5:0] op_onehot(input logic [2:0] op);
    op_onehot = (op <= 3'd5) ? (6'b000001 << op) : 6'b000000;
  endfunction

  assign push     = cmd_valid & cmd_ready & ~clr;
  assign pop      = (state == IDLE) && (count != '0);
  assign head_stb = op_onehot(fifo_op[rd_ptr]);

  assign alu_add = stb[0];
  assign alu_sub = stb[1];
  assign alu_and = stb[2];
  assign alu_mul = stb[3];
  assign alu_div = stb[4];
  assign al_lsb  = stb[5];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (!push && pop)
      count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr] <= cmd_op;
      fifo_a[wr_ptr]  <= cmd_a;
      fifo_b[wr_ptr]  <= cmd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
      stb       <= '0;
      wait_cnt  <= '0;
      AH_in     <= '0;
      BREG_in   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
      res_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_next;
      cmd_ready <= (count_next < CNT_W'(DEPTH));

      case (state)
        // Pop the head; operands stay on the ALU bus until the next pop.
        IDLE: begin
          if (pop) begin
            AH_in   <= fifo_a[rd_ptr];
            BREG_in <= fifo_b[rd_ptr];
            if (head_stb != '0) begin
              stb   <= head_stb;
              state <= ISSUE;
            end else begin
              res_err   <= 1'b1;
              res_data  <= '0;
              res_flags <= '0;
              res_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        // Strobe is high for exactly this one cycle.
        ISSUE: begin
          stb      <= '0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        // Capture on the LAT-th edge after the ALU registered the strobe.
        WAIT: begin
          if (wait_cnt == LAT_W'(LAT - 1)) begin
            res_data  <= ALU_out;
            res_flags <= {sign_flag, carry_flag, zero_flag};
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + LAT_W'(1);
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
